// File: rtl/host_loader_pkg.sv
// Shared types and constants for the host image loader.
package host_loader_pkg;

    typedef enum logic [1:0] {
        S_COLLECT = 2'd0,
        S_WRITE   = 2'd1,
        S_DONE    = 2'd2,
        S_ERROR   = 2'd3
    } state_t;

    localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
    localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;

    // Host beats per 32-bit word.
    function automatic int unsigned beats_of(input int unsigned host_w);
        return 32 / host_w;
    endfunction

endpackage

// File: rtl/host_loader_pack.sv
// Packs host beats into a big-endian 32-bit word with a byte-valid mask.
module host_loader_pack
    import host_loader_pkg::*;
#(
    parameter int unsigned HOST_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              shift,
    input  logic              clear,
    input  logic [HOST_W-1:0] data,
    output logic [31:0]       word,
    output logic [3:0]        mask,
    output logic              last_c,
    output logic              empty_c
);

    localparam int unsigned BEATS = beats_of(HOST_W);
    localparam int unsigned LANES = HOST_W / 8;
    localparam int unsigned CW    = 3;

    logic [CW-1:0] cnt;

    // Beat i lands in the i-th slot from the top; clear wins over shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
            mask <= '0;
            cnt  <= '0;
        end else if (clear) begin
            word <= '0;
            mask <= '0;
            cnt  <= '0;
        end else if (shift) begin
            for (int i = 0; i < BEATS; i++) begin
                if (cnt == CW'(i)) begin
                    word[31 - i*HOST_W -: HOST_W] <= data;
                    mask[3 - i*LANES -: LANES]    <= '1;
                end
            end
            cnt <= cnt + 1'b1;
        end
    end

    assign last_c  = (cnt == CW'(BEATS - 1));
    assign empty_c = (cnt == '0);

endmodule

// File: rtl/host_loader.sv
// Host image loader: packs host beats into words and writes them over Wishbone,
// holding the CPU in reset until the image is complete.
// Optional checksum: define HOST_LOADER_CSUM_EN.
module host_loader
    import host_loader_pkg::*;
#(
    parameter int unsigned HOST_W    = 8,
    parameter logic [31:0] BASE_ADR  = 32'h0000_0000,
    parameter logic [31:0] MAX_WORDS = 32'h0080_0000,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic [HOST_W-1:0] host_data_i,
    input  logic              host_valid_i,
    output logic              host_ready_o,
    input  logic              host_done_i,
    output logic              host_ack_o,
    output logic              host_err_o,
    output logic              cpu_rst_o,
    output logic [31:0]       word_count_o,
    output logic [31:0]       csum_o,
    output logic [31:0]       wbm_adr_o,
    output logic [31:0]       wbm_dat_o,
    output logic [3:0]        wbm_sel_o,
    output logic              wbm_we_o,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic [2:0]        wbm_cti_o,
    output logic [1:0]        wbm_bte_o,
    input  logic [31:0]       wbm_dat_i,
    input  logic              wbm_ack_i,
    input  logic              wbm_err_i
);

    state_t      state, state_nxt;
    logic        done_pend, done_pend_nxt;
    logic        accept_c, ack_take_c, full_c;
    logic        pack_last_c, pack_empty_c;
    logic [31:0] tmo_cnt;
    logic        unused_c;

    assign accept_c  = host_valid_i && host_ready_o;
    assign full_c    = (word_count_o == MAX_WORDS);
    assign wbm_cti_o = WB_CTI_CLASSIC;
    assign wbm_bte_o = WB_BTE_LINEAR;
    assign unused_c  = ^wbm_dat_i;

    host_loader_pack #(.HOST_W(HOST_W)) u_pack (
        .clk     (clk_i),
        .rst_n   (rst_n_i),
        .shift   (accept_c),
        .clear   (ack_take_c),
        .data    (host_data_i),
        .word    (wbm_dat_o),
        .mask    (wbm_sel_o),
        .last_c  (pack_last_c),
        .empty_c (pack_empty_c)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= S_COLLECT;
            done_pend <= 1'b0;
        end else begin
            state     <= state_nxt;
            done_pend <= done_pend_nxt;
        end
    end

    // Next-state logic; done is evaluated after this cycle's beat.
    always_comb begin
        state_nxt     = state;
        done_pend_nxt = done_pend;
        ack_take_c    = 1'b0;
        unique case (state)
            S_COLLECT: begin
                if (accept_c && pack_last_c) begin
                    done_pend_nxt = host_done_i;
                    state_nxt     = full_c ? S_ERROR : S_WRITE;
                end else if (host_done_i) begin
                    if (accept_c || !pack_empty_c) begin
                        done_pend_nxt = 1'b1;
                        state_nxt     = full_c ? S_ERROR : S_WRITE;
                    end else begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_WRITE: begin
                done_pend_nxt = done_pend || host_done_i;
                if (wbm_err_i) begin
                    state_nxt = S_ERROR;
                end else if (wbm_ack_i) begin
                    ack_take_c = 1'b1;
                    state_nxt  = done_pend_nxt ? S_DONE : S_COLLECT;
                end else if (tmo_cnt == 32'(TIMEOUT - 1)) begin
                    state_nxt = S_ERROR;
                end
            end
            default: ;
        endcase
    end

    // Registered control outputs decoded from the next state.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            host_ready_o <= 1'b0;
            host_ack_o   <= 1'b0;
            host_err_o   <= 1'b0;
            cpu_rst_o    <= 1'b1;
            wbm_cyc_o    <= 1'b0;
            wbm_stb_o    <= 1'b0;
            wbm_we_o     <= 1'b0;
        end else begin
            host_ready_o <= (state_nxt == S_COLLECT);
            host_ack_o   <= (state_nxt == S_DONE);
            host_err_o   <= (state_nxt == S_ERROR);
            cpu_rst_o    <= (state_nxt != S_DONE);
            wbm_cyc_o    <= (state_nxt == S_WRITE);
            wbm_stb_o    <= (state_nxt == S_WRITE);
            wbm_we_o     <= (state_nxt == S_WRITE);
        end
    end

    // Address, acked-word count and per-write timeout counter.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wbm_adr_o    <= BASE_ADR;
            word_count_o <= '0;
            tmo_cnt      <= '0;
        end else begin
            if (ack_take_c) begin
                wbm_adr_o    <= wbm_adr_o + 32'd4;
                word_count_o <= word_count_o + 32'd1;
            end
            tmo_cnt <= (state == S_WRITE) ? tmo_cnt + 32'd1 : '0;
        end
    end

`ifdef HOST_LOADER_CSUM_EN
    // Wrapping sum of every acked word.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            csum_o <= '0;
        end else if (ack_take_c) begin
            csum_o <= csum_o + wbm_dat_o;
        end
    end
`else
    assign csum_o = 32'd0;
`endif

endmodule
